// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// driving datapath enables, with a timed memory handshake, sticky trap and retire counter.
module multicycle_control_fsm #(
    parameter int ALUCTL_W    = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic                zero_ext,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(6);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(7);
    localparam logic [ALUCTL_W-1:0] ALU_SLL = ALUCTL_W'(14);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic [5:0]        op_q, fn_q;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  count_q;
    logic              retire;
    logic              op_ok, fn_ok;

    function automatic logic [ALUCTL_W-1:0] alu_of(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            default: return ALU_ADD;
        endcase
    endfunction

    // Legality is judged on the live IR fields during DECODE, before they are latched.
    always_comb begin
        op_ok = 1'b0;
        fn_ok = 1'b0;
        case (opcode)
            OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: op_ok = 1'b1;
            default: ;
        endcase
        case (funct)
            FN_SLL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: fn_ok = 1'b1;
            default: ;
        endcase
    end

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        cause_d = cause_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (op_q == OP_SW) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                if (!op_ok) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else if (opcode == OP_R && !fn_ok) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        if (fn_q == FN_JR) begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                    OP_LW, OP_SW:     state_d = S_MEM;
                    OP_ADDI, OP_ORI:  state_d = S_WB;
                    default: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            op_q    <= '0;
            fn_q    <= '0;
            cause_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_ctl     = '0;
        zero_ext    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        trap        = (state_q == S_TRAP);
        trap_cause  = cause_q;
        instr_count = count_q;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                alu_ctl   = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                alu_ctl   = ALU_ADD;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        if (fn_q == FN_JR) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd3;
                        end else begin
                            alu_src_a = 1'b1;
                            alu_ctl   = alu_of(fn_q);
                        end
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        alu_ctl   = ALU_ADD;
                    end
                    OP_ORI: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'd2;
                        alu_ctl   = ALU_OR;
                        zero_ext  = 1'b1;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_src_a = 1'b1;
                        alu_ctl   = ALU_SUB;
                        if ((op_q == OP_BEQ) == alu_zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                    end
                    OP_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end
                    OP_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = 2'd2;
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LW) begin
                    mem_to_reg = 2'd1;
                end else if (op_q == OP_R) begin
                    reg_dst = 2'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: a per-instruction cycle-script model predicts every output each cycle;
// directed instructions pin the model with literal values, then randomized traffic follows.
module tb_multicycle_control_fsm;

    localparam int ALUW = 5;
    localparam int TOUT = 4;
    localparam int CW   = 4;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23,
                           OP_SW = 6'h2B;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [5:0]      opcode = '0;
    logic [5:0]      funct = '0;
    logic            alu_zero = 1'b0;
    logic            mem_ready = 1'b0;
    logic            mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a;
    logic            zero_ext, reg_write, trap;
    logic [1:0]      pc_src, alu_src_b, reg_dst, mem_to_reg, trap_cause;
    logic [ALUW-1:0] alu_ctl;
    logic [CW-1:0]   instr_count;

    multicycle_control_fsm #(.ALUCTL_W(ALUW), .MEM_TIMEOUT(TOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .zero_ext(zero_ext), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            mem_req, mem_we, i_or_d, ir_write, pc_write;
        logic [1:0]      pc_src;
        logic            alu_src_a;
        logic [1:0]      alu_src_b;
        logic [ALUW-1:0] alu_ctl;
        logic            zero_ext, reg_write;
        logic [1:0]      reg_dst, mem_to_reg;
        logic            trap;
        logic [1:0]      trap_cause;
        logic [CW-1:0]   instr_count;
    } out_t;

    typedef struct {
        logic       rdy;
        logic       zero;
        logic [5:0] op;
        logic [5:0] fn;
        string      tag;
        out_t       exp;
    } cyc_t;

    cyc_t  q[$];
    out_t  snap[string];
    int    tagcnt[string];
    int    ncyc[string];
    int    n_checks = 0;
    int    n_errors = 0;
    int    m_count = 0;
    bit    m_trapped = 1'b0;
    logic [1:0] m_cause = 2'd0;

    function automatic out_t sample();
        out_t s;
        s.mem_req = mem_req;     s.mem_we = mem_we;         s.i_or_d = i_or_d;
        s.ir_write = ir_write;   s.pc_write = pc_write;     s.pc_src = pc_src;
        s.alu_src_a = alu_src_a; s.alu_src_b = alu_src_b;   s.alu_ctl = alu_ctl;
        s.zero_ext = zero_ext;   s.reg_write = reg_write;   s.reg_dst = reg_dst;
        s.mem_to_reg = mem_to_reg; s.trap = trap;           s.trap_cause = trap_cause;
        s.instr_count = instr_count;
        return s;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: one cycle script per instruction ----------------
    function automatic out_t blank();
        out_t o = '0;
        o.instr_count = CW'(m_count);
        return o;
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic void push(input string tag, input logic rdy, input logic zero,
                                 input logic [5:0] op, input logic [5:0] fn, input out_t o);
        cyc_t c;
        c.rdy = rdy; c.zero = zero; c.op = op; c.fn = fn; c.tag = tag; c.exp = o;
        q.push_back(c);
    endfunction

    function automatic void retire();
        m_count = (m_count + 1) % (1 << CW);
    endfunction

    function automatic void enter_trap(input logic [1:0] c);
        m_trapped = 1'b1;
        m_cause   = c;
    endfunction

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW};
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08};
    endfunction

    function automatic int alu_code(input logic [5:0] fn);
        case (fn)
            6'h20: return 2;
            6'h22: return 6;
            6'h24: return 0;
            6'h25: return 1;
            6'h2A: return 7;
            6'h00: return 14;
            default: return -1;
        endcase
    endfunction

    // Returns 1 if the access completed, 0 if it timed out into a trap.
    function automatic bit access(input string tag, input int waits, input bit is_fetch,
                                  input bit is_store);
        out_t o;
        for (int k = 0; k <= waits; k++) begin
            o = blank();
            o.mem_req = 1'b1;
            if (is_fetch) begin
                o.alu_src_b = 2'd1;
                o.alu_ctl   = ALUW'(2);
            end else begin
                o.i_or_d = 1'b1;
                o.mem_we = is_store;
            end
            if (k < waits) begin
                push(tag, 1'b0, rbit(), junk(), junk(), o);
                if (k == TOUT) begin
                    enter_trap(2'd3);
                    return 1'b0;
                end
            end else begin
                o.ir_write = is_fetch;
                o.pc_write = is_fetch;
                push(tag, 1'b1, rbit(), junk(), junk(), o);
            end
        end
        return 1'b1;
    endfunction

    function automatic void writeback(input string p, input logic [1:0] dst,
                                      input logic [1:0] m2r);
        out_t o = blank();
        o.reg_write  = 1'b1;
        o.reg_dst    = dst;
        o.mem_to_reg = m2r;
        push({p, ".W"}, rbit(), rbit(), junk(), junk(), o);
        retire();
    endfunction

    function automatic void gen(input string p, input logic [5:0] op, input logic [5:0] fn,
                                input int fw, input int mw, input logic zero);
        out_t o;
        bit   taken;
        if (m_trapped) return;
        if (!access({p, ".F"}, fw, 1'b1, 1'b0)) return;
        o = blank();
        o.alu_src_b = 2'd3;
        o.alu_ctl   = ALUW'(2);
        push({p, ".D"}, rbit(), rbit(), op, fn, o);
        if (!legal_op(op)) begin
            enter_trap(2'd1);
            return;
        end
        if (op == OP_R && !legal_fn(fn)) begin
            enter_trap(2'd2);
            return;
        end
        o = blank();
        case (op)
            OP_R: begin
                if (fn == 6'h08) begin
                    o.pc_write = 1'b1;
                    o.pc_src   = 2'd3;
                    push({p, ".E"}, rbit(), rbit(), junk(), junk(), o);
                    retire();
                end else begin
                    o.alu_src_a = 1'b1;
                    o.alu_ctl   = ALUW'(alu_code(fn));
                    push({p, ".E"}, rbit(), rbit(), junk(), junk(), o);
                    writeback(p, 2'd1, 2'd0);
                end
            end
            OP_LW, OP_SW: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'd2;
                o.alu_ctl   = ALUW'(2);
                push({p, ".E"}, rbit(), rbit(), junk(), junk(), o);
                if (access({p, ".M"}, mw, 1'b0, op == OP_SW)) begin
                    if (op == OP_SW) retire();
                    else writeback(p, 2'd0, 2'd1);
                end
            end
            OP_ADDI, OP_ORI: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'd2;
                o.alu_ctl   = ALUW'(op == OP_ORI ? 1 : 2);
                o.zero_ext  = (op == OP_ORI);
                push({p, ".E"}, rbit(), rbit(), junk(), junk(), o);
                writeback(p, 2'd0, 2'd0);
            end
            OP_BEQ, OP_BNE: begin
                taken       = (op == OP_BEQ) ? zero : !zero;
                o.alu_src_a = 1'b1;
                o.alu_ctl   = ALUW'(6);
                o.pc_write  = taken;
                o.pc_src    = taken ? 2'd1 : 2'd0;
                push({p, ".E"}, rbit(), zero, junk(), junk(), o);
                retire();
            end
            default: begin
                o.pc_write = 1'b1;
                o.pc_src   = 2'd2;
                if (op == OP_JAL) begin
                    o.reg_write  = 1'b1;
                    o.reg_dst    = 2'd2;
                    o.mem_to_reg = 2'd2;
                end
                push({p, ".E"}, rbit(), rbit(), junk(), junk(), o);
                retire();
            end
        endcase
    endfunction

    function automatic void push_trap(input string p, input int n);
        out_t o;
        for (int i = 0; i < n; i++) begin
            o = blank();
            o.trap       = 1'b1;
            o.trap_cause = m_cause;
            push({p, ".T"}, rbit(), rbit(), junk(), junk(), o);
        end
    endfunction

    // ---------------- drive + compare ----------------
    task automatic run(input string stop_tag);
        cyc_t  c;
        out_t  act;
        string pfx;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            mem_ready = c.rdy;
            alu_zero  = c.zero;
            opcode    = c.op;
            funct     = c.fn;
            @(negedge clk);
            act = sample();
            check(c.tag, act, c.exp);
            snap[c.tag]   = act;
            tagcnt[c.tag] = tagcnt.exists(c.tag) ? tagcnt[c.tag] + 1 : 1;
            pfx           = c.tag.substr(0, c.tag.len() - 3);
            ncyc[pfx]     = ncyc.exists(pfx) ? ncyc[pfx] + 1 : 1;
            if (stop_tag != "" && c.tag == stop_tag) begin
                q.delete();
                break;
            end
        end
    endtask

    task automatic do_reset(input string name);
        #1;
        rst_n = 1'b0;
        #1;
        check({name, ".async"}, sample(), out_t'('0));
        q.delete();
        m_count   = 0;
        m_trapped = 1'b0;
        m_cause   = 2'd0;
        @(negedge clk);
        check({name, ".hold"}, sample(), out_t'('0));
        rst_n = 1'b1;
    endtask

    function automatic out_t get(input string tag);
        if (snap.exists(tag)) return snap[tag];
        return 'x;
    endfunction

    logic [5:0] op_tab [9] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW};
    logic [5:0] fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h08};

    initial begin
        out_t       s;
        logic [5:0] op, fn;
        int         fw, mw;

        do_reset("reset0");

        // Directed instructions, all with immediate mem_ready unless noted.
        gen("add", OP_R, 6'h20, 0, 0, 1'b0);
        gen("lw", OP_LW, junk(), 0, 3, 1'b0);
        gen("beq1", OP_BEQ, junk(), 0, 0, 1'b1);
        gen("beq0", OP_BEQ, junk(), 0, 0, 1'b0);
        gen("jal", OP_JAL, junk(), 0, 0, 1'b0);
        gen("ori", OP_ORI, junk(), 0, 0, 1'b0);
        gen("nx", OP_J, junk(), 0, 0, 1'b0);
        run("");
        s = get("add.E");
        check_lit("add.E.alu_ctl", int'(s.alu_ctl), 2);
        check_lit("add.E.src_a", int'(s.alu_src_a), 1);
        check_lit("add.E.src_b", int'(s.alu_src_b), 0);
        s = get("add.W");
        check_lit("add.W.reg_write", int'(s.reg_write), 1);
        check_lit("add.W.reg_dst", int'(s.reg_dst), 1);
        check_lit("add.latency", ncyc["add"], 4);
        s = get("lw.F");
        check_lit("count_after_add", int'(s.instr_count), 1);
        check_lit("lw.mem_cycles", tagcnt["lw.M"], 4);
        s = get("lw.M");
        check_lit("lw.M.req_iord", int'({s.mem_req, s.i_or_d}), 3);
        s = get("lw.W");
        check_lit("lw.W.mem_to_reg", int'(s.mem_to_reg), 1);
        check_lit("lw.latency", ncyc["lw"], 8);
        s = get("beq1.E");
        check_lit("beq1.E.pc_write", int'(s.pc_write), 1);
        check_lit("beq1.E.pc_src", int'(s.pc_src), 1);
        s = get("beq0.E");
        check_lit("beq0.E.pc_write", int'(s.pc_write), 0);
        check_lit("beq1.latency", ncyc["beq1"], 3);
        check_lit("beq0.latency", ncyc["beq0"], 3);
        s = get("jal.E");
        check_lit("jal.E.fields", int'({s.pc_src, s.reg_write, s.reg_dst, s.mem_to_reg}),
                  int'({2'd2, 1'b1, 2'd2, 2'd2}));
        s = get("ori.E");
        check_lit("ori.E.zero_ext", int'(s.zero_ext), 1);
        check_lit("ori.E.alu_ctl", int'(s.alu_ctl), 1);
        s = get("nx.F");
        check_lit("count_after_six", int'(s.instr_count), 6);

        // Illegal opcode and illegal funct trap, hold, and clear on reset.
        do_reset("reset1");
        gen("ill", 6'h3F, 6'h20, 0, 0, 1'b0);
        push_trap("ill", 3);
        run("");
        s = get("ill.T");
        check_lit("ill.trap_cause", int'({s.trap, s.trap_cause}), int'({1'b1, 2'd1}));
        do_reset("reset2");
        gen("ilf", OP_R, 6'h3F, 0, 0, 1'b0);
        push_trap("ilf", 3);
        run("");
        s = get("ilf.T");
        check_lit("ilf.trap_cause", int'({s.trap, s.trap_cause}), int'({1'b1, 2'd2}));

        // Fetch timeout, then reset in the middle of a data access.
        do_reset("reset3");
        gen("to", OP_R, 6'h20, 10, 0, 1'b0);
        push_trap("to", 3);
        run("");
        check_lit("to.fetch_cycles", tagcnt["to.F"], TOUT + 1);
        s = get("to.T");
        check_lit("to.trap_cause", int'(s.trap_cause), 3);
        do_reset("reset4");
        gen("mr", OP_LW, junk(), 0, 3, 1'b0);
        run("mr.M");
        do_reset("reset_mid_mem");

        // Retire counter wraps at 2^CW.
        for (int i = 0; i < 16; i++) gen("w", OP_J, junk(), 0, 0, 1'b0);
        gen("wend", OP_J, junk(), 0, 0, 1'b0);
        run("");
        s = get("wend.F");
        check_lit("count_wrap", int'(s.instr_count), 0);

        // Randomized traffic.
        do_reset("reset5");
        for (int i = 0; i < 300; i++) begin
            op = op_tab[$urandom_range(0, 8)];
            fn = (op == OP_R) ? fn_tab[$urandom_range(0, 6)] : junk();
            if ($urandom_range(0, 15) == 0) begin
                do op = junk(); while (legal_op(op));
            end else if (op == OP_R && $urandom_range(0, 15) == 0) begin
                do fn = junk(); while (legal_fn(fn));
            end
            fw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            gen("r", op, fn, fw, mw, rbit());
            if (m_trapped) push_trap("r", 2);
            run("");
            if (m_trapped) do_reset("reset_r");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
